// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit: forward-select codes and
// the mul/div scoreboard state machine.
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_BUSY = 2'b01,
      MD_DONE = 2'b10
   } mdState_t;

endpackage

// File: rtl/md_scoreboard.sv
// One-entry scoreboard for the multi-cycle mul/div unit launched from E.
// Tracks the pending destination register and the remaining latency.
module md_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int MD_LAT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mdStart,
   input  logic              stallE,
   input  logic [REG_AW-1:0] writeRegE,
   input  logic              regWriteE,
   output mdState_t          mdState,
   output logic [REG_AW-1:0] mdDst,
   output logic              mdValid,
   output logic              mdBusy,
   output logic              mdDone
);

   localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

   logic [CW-1:0] cnt;

   // NOTE: all state here is sequential, so every assignment uses <=; a blocking
   // assignment would let later statements see the new value within the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         mdState <= MD_IDLE;
         cnt     <= '0;
         mdDst   <= '0;
         mdValid <= 1'b0;
         mdBusy  <= 1'b0;
         mdDone  <= 1'b0;
      end else begin
         case (mdState)
            MD_IDLE: begin
               if (mdStart && !stallE) begin
                  mdDst   <= writeRegE;
                  mdValid <= regWriteE && (writeRegE != '0);
                  cnt     <= CW'(MD_LAT - 2);
                  mdState <= MD_BUSY;
                  mdBusy  <= 1'b1;
               end
            end
            // Latency counts regardless of pipeline stalls.
            MD_BUSY: begin
               if (cnt == '0) begin
                  mdState <= MD_DONE;
                  mdDone  <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            MD_DONE: begin
               mdState <= MD_IDLE;
               mdValid <= 1'b0;
               mdBusy  <= 1'b0;
               mdDone  <= 1'b0;
            end
            default: begin
               mdState <= MD_IDLE;
               mdBusy  <= 1'b0;
               mdDone  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use/branch/mul-div
// stalls, memory-wait stalls, jump flush and saturating stall/flush counters.
module hazard_unit_mc
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              BranchD,
   input  logic              JumpD,
   input  logic [REG_AW-1:0] RsD,
   input  logic [REG_AW-1:0] RtD,
   input  logic [REG_AW-1:0] WriteRegD,
   input  logic              RegWriteD,
   input  logic [REG_AW-1:0] RsE,
   input  logic [REG_AW-1:0] RtE,
   input  logic [REG_AW-1:0] WriteRegE,
   input  logic              RegWriteE,
   input  logic              MemtoRegE,
   input  logic              MdStartE,
   input  logic [REG_AW-1:0] WriteRegM,
   input  logic              RegWriteM,
   input  logic              MemtoRegM,
   input  logic              MemWriteM,
   input  logic              MemReadyM,
   input  logic [REG_AW-1:0] WriteRegW,
   input  logic              RegWriteW,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              StallM,
   output logic              FlushE,
   output logic              FlushM,
   output logic              FlushW,
   output logic              ForwardAD,
   output logic              ForwardBD,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              MdBusy,
   output logic              MdDone,
   output logic [CNT_W-1:0]  StallCycles,
   output logic [CNT_W-1:0]  FlushCycles
);

   mdState_t          mdState;
   logic [REG_AW-1:0] mdDst;
   logic              mdValid;
   logic              lwStall, branchStall, mdRaw, mdStruct, memStall;

   function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src);
      if (src != '0 && src == WriteRegM && RegWriteM)      return FWD_MEM;
      else if (src != '0 && src == WriteRegW && RegWriteW) return FWD_WB;
      else                                                 return FWD_RF;
   endfunction

   assign ForwardAE = fwdSel(RsE);
   assign ForwardBE = fwdSel(RtE);
   assign ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
   assign ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;

   assign lwStall = MemtoRegE && (RtE != '0) && ((RsD == RtE) || (RtD == RtE));
   assign branchStall = BranchD &&
      ((RegWriteE && (WriteRegE != '0) && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
       (MemtoRegM && (WriteRegM != '0) && ((WriteRegM == RsD) || (WriteRegM == RtD))));
   // The DONE cycle releases the dependency: the register file writes through.
   assign mdRaw = MdBusy && mdValid && (mdState != MD_DONE) &&
      ((mdDst == RsD) || (mdDst == RtD) || (RegWriteD && (mdDst == WriteRegD)));
   assign mdStruct = MdStartE && (mdState != MD_IDLE);
   assign memStall = !MemReadyM && (MemtoRegM || MemWriteM);

   // NOTE: every output gets a default before the priority chain so no path
   // leaves a signal unassigned, which would infer a latch.
   always_comb begin
      {StallF, StallD, StallE, StallM} = 4'b0000;
      {FlushE, FlushM, FlushW}         = 3'b000;
      if (memStall) begin
         {StallF, StallD, StallE, StallM} = 4'b1111;
         FlushW = 1'b1;
      end else if (mdStruct) begin
         {StallF, StallD, StallE} = 3'b111;
         FlushM = 1'b1;
      end else if (lwStall || branchStall || mdRaw) begin
         {StallF, StallD} = 2'b11;
         FlushE = 1'b1;
      end else if (JumpD) begin
         FlushE = 1'b1;
      end
   end

   md_scoreboard #(.REG_AW(REG_AW), .MD_LAT(MD_LAT)) u_md (
      .clk       (clk),
      .reset     (reset),
      .mdStart   (MdStartE),
      .stallE    (StallE),
      .writeRegE (WriteRegE),
      .regWriteE (RegWriteE),
      .mdState   (mdState),
      .mdDst     (mdDst),
      .mdValid   (mdValid),
      .mdBusy    (MdBusy),
      .mdDone    (MdDone)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         StallCycles <= '0;
         FlushCycles <= '0;
      end else begin
         if (StallF && (StallCycles != '1))
            StallCycles <= StallCycles + CNT_W'(1);
         if ((FlushE || FlushM || FlushW) && (FlushCycles != '1))
            FlushCycles <= FlushCycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: a behavioural reference model pushes
// expected outputs into a queue each cycle; they are popped when sampled.
module tb_hazard_unit_mc;

   localparam int REG_AW = 5;
   localparam int MD_LAT = 4;
   localparam int CNT_W  = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;
   logic BranchD, JumpD, RegWriteD, RegWriteE, MemtoRegE, MdStartE;
   logic RegWriteM, MemtoRegM, MemWriteM, MemReadyM, RegWriteW;
   logic [REG_AW-1:0] RsD, RtD, WriteRegD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic StallF, StallD, StallE, StallM, FlushE, FlushM, FlushW;
   logic ForwardAD, ForwardBD, MdBusy, MdDone;
   logic [1:0] ForwardAE, ForwardBE;
   logic [CNT_W-1:0] StallCycles, FlushCycles;

   always #5 clk = ~clk;

   hazard_unit_mc #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .BranchD(BranchD), .JumpD(JumpD),
      .RsD(RsD), .RtD(RtD), .WriteRegD(WriteRegD), .RegWriteD(RegWriteD),
      .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MdStartE(MdStartE),
      .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
      .MemWriteM(MemWriteM), .MemReadyM(MemReadyM),
      .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .MdBusy(MdBusy), .MdDone(MdDone),
      .StallCycles(StallCycles), .FlushCycles(FlushCycles)
   );

   typedef struct {
      logic [3:0] stall;   // {F,D,E,M}
      logic [2:0] flush;   // {E,M,W}
      logic [1:0] fwdD;    // {AD,BD}
      logic [1:0] fwdAE;
      logic [1:0] fwdBE;
      logic       busy;
      logic       done;
      int         sc;
      int         fc;
   } exp_t;

   exp_t expQ[$];
   int   nChecks = 0;
   int   nPass   = 0;
   int   cycle   = 0;

   // Reference model state
   int         mState = 0;   // 0 idle, 1 busy, 2 done
   int         mCnt   = 0;
   logic [4:0] mDst   = '0;
   bit         mValid = 1'b0;
   int         mSc    = 0;
   int         mFc    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      nChecks++;
      if (got === want) nPass++;
      else $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cycle, got, want);
   endtask

   function automatic logic [1:0] refFwd(input logic [4:0] src);
      if (src == 0) return 2'b00;
      if (RegWriteM && src == WriteRegM) return 2'b10;
      if (RegWriteW && src == WriteRegW) return 2'b01;
      return 2'b00;
   endfunction

   function automatic exp_t predict();
      exp_t e;
      bit memS, structS, lw, br, raw;
      memS    = !MemReadyM && (MemtoRegM || MemWriteM);
      structS = MdStartE && mState != 0;
      lw      = MemtoRegE && RtE != 0 && (RsD == RtE || RtD == RtE);
      br      = BranchD &&
                ((RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
                 (MemtoRegM && WriteRegM != 0 && (WriteRegM == RsD || WriteRegM == RtD)));
      raw     = mState == 1 && mValid &&
                (mDst == RsD || mDst == RtD || (RegWriteD && mDst == WriteRegD));
      e.stall = 4'b0000;
      e.flush = 3'b000;
      if (memS)                 begin e.stall = 4'b1111; e.flush = 3'b001; end
      else if (structS)         begin e.stall = 4'b1110; e.flush = 3'b010; end
      else if (lw || br || raw) begin e.stall = 4'b1100; e.flush = 3'b100; end
      else if (JumpD)           e.flush = 3'b100;
      e.fwdD  = {RsD != 0 && RegWriteM && RsD == WriteRegM,
                 RtD != 0 && RegWriteM && RtD == WriteRegM};
      e.fwdAE = refFwd(RsE);
      e.fwdBE = refFwd(RtE);
      e.busy  = mState != 0;
      e.done  = mState == 2;
      e.sc    = mSc;
      e.fc    = mFc;
      return e;
   endfunction

   // Called just after a falling edge with inputs already driven.
   task automatic step();
      exp_t e, o;
      #1;
      e = predict();
      expQ.push_back(e);
      #2;
      o = expQ.pop_front();
      check("stall",  {28'd0, StallF, StallD, StallE, StallM}, {28'd0, o.stall});
      check("flush",  {29'd0, FlushE, FlushM, FlushW},         {29'd0, o.flush});
      check("fwdD",   {30'd0, ForwardAD, ForwardBD},           {30'd0, o.fwdD});
      check("fwdAE",  {30'd0, ForwardAE},                      {30'd0, o.fwdAE});
      check("fwdBE",  {30'd0, ForwardBE},                      {30'd0, o.fwdBE});
      check("mdBusy", {31'd0, MdBusy},                         {31'd0, o.busy});
      check("mdDone", {31'd0, MdDone},                         {31'd0, o.done});
      check("stallCycles", {28'd0, StallCycles},               o.sc);
      check("flushCycles", {28'd0, FlushCycles},               o.fc);
      // Advance the model across the rising edge
      if (reset) begin
         mState = 0; mCnt = 0; mDst = '0; mValid = 0; mSc = 0; mFc = 0;
      end else begin
         case (mState)
            0: if (MdStartE && !e.stall[1]) begin
                  mDst = WriteRegE; mValid = RegWriteE && WriteRegE != 0;
                  mCnt = MD_LAT - 2; mState = 1;
               end
            1: if (mCnt == 0) mState = 2; else mCnt--;
            default: begin mState = 0; mValid = 0; end
         endcase
         if (e.stall[3] && mSc < CMAX) mSc++;
         if (e.flush != 0 && mFc < CMAX) mFc++;
      end
      @(negedge clk);
      cycle++;
   endtask

   task automatic clearIn();
      {BranchD, JumpD, RegWriteD, RegWriteE, MemtoRegE, MdStartE} = '0;
      {RegWriteM, MemtoRegM, MemWriteM, RegWriteW} = '0;
      MemReadyM = 1'b1;
      {RsD, RtD, WriteRegD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
   endtask

   task automatic doReset();
      reset = 1'b1; step(); reset = 1'b0;
   endtask

   initial begin
      clearIn();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      step();   // reset state

      // Forwarding: M priority, W fallback, r0 never forwarded
      RsE = 3; RtE = 3; WriteRegM = 3; WriteRegW = 3; RegWriteM = 1; RegWriteW = 1;
      RsD = 3; step();
      RegWriteM = 0; step();
      RsE = 0; step();
      clearIn();

      // Load-use, then the same case with RtE = 0
      MemtoRegE = 1; RtE = 8; RsD = 8; step();
      clearIn(); step();
      MemtoRegE = 1; RtE = 0; RsD = 0; step();
      clearIn();

      // Branch dependencies on E and on a load in M, then a jump
      BranchD = 1; RsD = 4; RegWriteE = 1; WriteRegE = 4; step();
      clearIn(); BranchD = 1; RtD = 9; MemtoRegM = 1; WriteRegM = 9; step();
      clearIn(); JumpD = 1; step();
      clearIn();

      // MD RAW/latency: accept at t, RsD=5 stalled t+1..t+3, released at t+4
      doReset();
      MdStartE = 1; WriteRegE = 5; RegWriteE = 1; step();
      clearIn(); RsD = 5;
      repeat (5) step();
      clearIn();

      // MD structural: second op held from t+2 through DONE, accepted after
      MdStartE = 1; WriteRegE = 5; RegWriteE = 1; step();
      clearIn(); RsD = 5; step();
      MdStartE = 1; WriteRegE = 6; RegWriteE = 1;
      repeat (4) step();
      clearIn(); WriteRegD = 6; RegWriteD = 1;
      repeat (5) step();
      clearIn();

      // Memory wait with lwstall, JumpD and a new MD op all pending
      MdStartE = 1; WriteRegE = 7; RegWriteE = 1; step();
      clearIn();
      MemReadyM = 0; MemtoRegM = 1; MemtoRegE = 1; RtE = 8; RsD = 8; JumpD = 1;
      repeat (4) step();
      MdStartE = 1; WriteRegE = 2; RegWriteE = 1;
      repeat (2) step();
      clearIn(); MemReadyM = 0; MemWriteM = 1; step();
      clearIn(); step();

      // Reset mid-BUSY: op abandoned, no MdDone afterwards
      MdStartE = 1; WriteRegE = 5; RegWriteE = 1; step();
      clearIn(); step();
      doReset();
      repeat (5) step();

      // Counter saturation
      MemtoRegE = 1; RtE = 8; RsD = 8;
      repeat (20) step();
      clearIn(); step();

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Parametrised second-generation hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W).
- Keeps the existing RAW forwarding, load-use stall, branch-in-D stall and jump flush.
- Adds a one-entry scoreboard for a multi-cycle mul/div unit that launches from E, data-memory wait stalls, and saturating stall/flush performance counters.
- Sits beside the datapath and drives all stall, flush and forward selects.

Parameters:
- REG_AW, 5: register-address width.
- MD_LAT, 4: mul/div latency in cycles from accept to result write (>=2).
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- BranchD, JumpD  in  1  branch/jump in D
- RsD, RtD, WriteRegD  in  REG_AW  D-stage sources and destination
- RegWriteD  in  1  D instruction writes the register file
- RsE, RtE, WriteRegE  in  REG_AW  E-stage sources and destination
- RegWriteE, MemtoRegE  in  1  E control
- MdStartE  in  1  E holds a mul/div op
- WriteRegM  in  REG_AW; RegWriteM, MemtoRegM, MemWriteM  in  1  M control
- MemReadyM  in  1  data memory ready
- WriteRegW  in  REG_AW; RegWriteW  in  1  W control
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushE, FlushM, FlushW  out  1  insert bubble into that stage register
- ForwardAD, ForwardBD  out  1  branch comparator takes the M-stage result
- ForwardAE, ForwardBE  out  2  00 register file, 01 W result, 10 M result
- MdBusy  out  1  scoreboard entry valid
- MdDone  out  1  one-cycle pulse: mul/div result written this cycle
- StallCycles, FlushCycles  out  CNT_W  saturating counters

Behaviour:
- Reset (synchronous, active-high, clk) → MD FSM returns to IDLE, md_valid=0, md_dst=0, MdBusy=0, MdDone=0, counters=0.
  - Reset mid-operation abandons the op; no MdDone is issued.
  - Combinational outputs follow the equations below with the reset state.
- Forwarding into E, per source X∈{Rs,Rt}:
  - 10 if XE!=0 && XE==WriteRegM && RegWriteM;
  - else 01 if XE!=0 && XE==WriteRegW && RegWriteW;
  - else 00.
  - M has priority over W.
- ForwardAD = RsD!=0 && RsD==WriteRegM && RegWriteM. ForwardBD is the same using RtD.
- lwstall = MemtoRegE && RtE!=0 && (RsD==RtE || RtD==RtE).
- branchstall = BranchD && one of:
  - RegWriteE && WriteRegE!=0 && WriteRegE∈{RsD,RtD};
  - MemtoRegM && WriteRegM!=0 && WriteRegM∈{RsD,RtD}.
- MD FSM, states IDLE → BUSY → DONE → IDLE:
  - IDLE: accept when MdStartE && !StallE. Then md_dst←WriteRegE, md_valid←RegWriteE && WriteRegE!=0, cnt←MD_LAT-2, go to BUSY.
  - BUSY: cnt decrements each cycle; at cnt==0 go to DONE. The FSM counts regardless of pipeline stalls.
  - DONE: MdDone=1 for exactly one cycle (the mul/div unit writes md_dst), then md_valid←0 and state→IDLE.
  - Accept-to-MdDone latency = MD_LAT cycles. MdBusy=1 in BUSY and DONE.
- mdraw = MdBusy && md_valid && state!=DONE && md_dst matches any of RsD, RtD, or WriteRegD with RegWriteD (RAW or WAW).
  - Released in the DONE cycle: the register file is write-through.
- mdstruct = MdStartE && state!=IDLE.
- memstall = !MemReadyM && (MemtoRegM || MemWriteM).
- Priority, highest first:
  1. memstall → StallF=StallD=StallE=StallM=1, FlushW=1. All other flushes 0.
  2. mdstruct → StallF=StallD=StallE=1, FlushM=1.
  3. lwstall || branchstall || mdraw → StallF=StallD=1, FlushE=1.
  4. JumpD → FlushE=1.
  5. Otherwise all stall/flush outputs 0.
- A new MD op is never accepted while memstall or mdstruct holds E.
- StallCycles increments when StallF=1; FlushCycles increments when FlushE||FlushM||FlushW. Both saturate at all-ones and never wrap.

Decomposition:
- Shared package hazard_pkg:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - MD state encoding MD_IDLE/MD_BUSY/MD_DONE.
- Sub-module md_scoreboard: FSM, latency counter, md_dst/md_valid; outputs MdBusy, MdDone, state.
- Top level holds the forwarding, stall/flush priority logic and the counters.

Test Plan:
- Forwarding: RsE=RtE=3 with WriteRegM=WriteRegW=3, both RegWrite=1 → ForwardAE=ForwardBE=10. With RegWriteM=0 → 01. With RsE=0 → 00.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 → StallF=StallD=FlushE=1 for one cycle. Same case with RtE=0 → no stall.
- MD RAW/latency (MD_LAT=4): accept op with WriteRegE=5 at cycle t.
  - MdDone at t+4.
  - D instruction with RsD=5 stalled over t+1..t+3 and released at t+4.
  - StallCycles incremented by 3.
- MD structural: second MdStartE at t+2 → StallE=1, FlushM=1 until the DONE cycle. Accepted the cycle after DONE, when the FSM is IDLE.
- Memory wait with simultaneous events: MemReadyM=0, MemtoRegM=1 while lwstall and JumpD are also true → only the memstall pattern (StallF/D/E/M=1, FlushW=1). The MD counter keeps counting.
- Reset mid-BUSY, then counter saturation: assert reset during BUSY → MdBusy=0 next cycle and no MdDone. With CNT_W=4, stall for 20 cycles → StallCycles holds at 15.
